// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct encodings and the fetch-stage state type.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SUBI  = 6'b001001;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC target select (JR > J > taken branch > sequential).
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        jump_reg_sel,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic        is_jr;
    logic        take_branch;
    logic [31:0] branch_off;

    assign is_jr       = jump_reg_sel && (instr_low[5:0] == FUNCT_JR);
    assign take_branch = (branch && zero) || (bne && !zero);
    assign branch_off  = {{14{instr_low[15]}}, instr_low[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (is_jr) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_low, 2'b00};
        end else if (take_branch) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // Only the JR target comes from a register and can be misaligned.
    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: req/ack fetch with timeout retry, hold until retire.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        jump_reg_sel,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic        fetch_err,
    output logic        addr_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_err_q, fetch_err_d;
    logic             addr_err_q, addr_err_d;

    logic [31:0]      next_pc;
    logic             next_misaligned;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_logic u_next_pc (
        .pc_plus4     (pc_plus4),
        .instr_low    (instr_q[25:0]),
        .branch       (branch),
        .bne          (bne),
        .jump         (jump),
        .jump_reg_sel (jump_reg_sel),
        .zero         (zero),
        .rs_data      (rs_data),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
        addr_err_d  = addr_err_q;

        case (state_q)
            FETCH: begin
                // req is low only in the first cycle after reset; raise it then.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    fetch_err_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                if (retire) begin
                    valid_d = 1'b0;
                    if (next_misaligned) begin
                        addr_err_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = next_pc;
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign fetch_err   = fetch_err_q;
    assign addr_err    = addr_err_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage of the single-cycle CPU.
- Sits directly upstream of the main control decoder, which receives `opcode`.
- Fetches one word from instruction memory over a req/ack handshake and holds it stable until the datapath retires it.
- Then computes the next PC from the decoder's Branch/BNE/Jump/JumpRegSel outputs and the ALU zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ACK_TIMEOUT, 16, max cycles waiting for `imem_ack` before `fetch_err`; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- imem_req  output  1  fetch request, held until ack
- imem_addr  output  32  word address (= pc) while imem_req
- imem_ack  input  1  rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- instr  output  32  held instruction register
- instr_valid  output  1  instr is valid for decode/execute
- opcode  output  6  instr[31:26], to control decoder
- pc  output  32  address of instr
- pc_plus4  output  32  pc+4 (link/branch base)
- retire  input  1  datapath has committed instr this cycle
- branch  input  1  decoder Branch (BEQ)
- bne  input  1  decoder BNE
- jump  input  1  decoder Jump
- jump_reg_sel  input  1  decoder JumpRegSel (asserted for all R-type)
- zero  input  1  ALU zero flag
- rs_data  input  32  register rs value (JR target)
- fetch_err  output  1  sticky: ack timeout
- addr_err  output  1  sticky: misaligned next PC

Behaviour:
- Synchronous reset (rst_n=0 at posedge): pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, imem_req=0, fetch_err=0, addr_err=0, timeout counter=0.
- Reset overrides everything, including a pending ack or retire in the same cycle.
- State FETCH:
  - imem_req=1 starting the first cycle after reset release; imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, imem_req<=0, go EXEC. instr_valid=1 from the next cycle. Ack-to-valid latency is 1 cycle.
  - An ack in the same cycle as req rise is legal.
  - Timeout counter increments each cycle without ack. On reaching ACK_TIMEOUT: set fetch_err, clear the counter, stay in FETCH and keep requesting (retry).
  - Counter clears on ack.
- State EXEC:
  - instr_valid=1; instr and pc are stable and imem_req=0.
  - On retire: compute nextpc, and instr_valid<=0 next cycle.
  - If nextpc[1:0]!=0: set addr_err, go HALT.
  - Otherwise pc<=nextpc, go FETCH.
  - retire is ignored in FETCH and HALT.
- State HALT: imem_req=0, instr_valid=0; exits only via reset.
- nextpc priority, evaluated in the retire cycle:
  1. jump_reg_sel && instr[5:0]==6'b001000 (JR) -> rs_data.
  2. jump -> {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. (branch && zero) || (bne && !zero) -> pc_plus4 + (sext(instr[15:0]) << 2).
  4. otherwise -> pc_plus4.
- Arithmetic: all adds are 32-bit modulo 2^32; wrap-around is silent (0xFFFF_FFFC+4 = 0).
- Combinational outputs:
  - pc_plus4 = pc + 4.
  - opcode = instr[31:26], valid only while instr_valid.
- Only JR is misaligned-capable; jump and branch targets are always word-aligned by construction.
- branch and bne both asserted: either condition selects the branch target; no error.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_RTYPE 6'b000000, OP_J 6'b000010, OP_BEQ 6'b000100, OP_BNE 6'b000101, OP_LUI 6'b001111, OP_LW, OP_SW, OP_SUBI, OP_ANDI, OP_XORI, OP_SLTIU
  - FUNCT_JR 6'b001000
  - fetch state enum {FETCH, EXEC, HALT}
- One natural sub-module: next_pc_logic (purely combinational target select, reusable by a later pipelined fetch).
- The FSM, timeout counter and registers stay in fetch_unit.

Test Plan:
- Reset release, imem_ack after 2 cycles with rdata=32'h2008_0005 -> imem_addr=0; instr_valid rises 1 cycle after ack; opcode=6'b001000; retire -> next imem_addr=4.
- BEQ at pc=0x10, instr=32'h1000_FFFE, zero=1, retire -> next pc=0x0C; same with zero=0 -> 0x14.
- BNE at pc=0x20, imm=3, zero=0 -> 0x30. Jump instr=32'h0800_0040 at pc=0x40 -> 0x100.
- JR (funct 001000, jump_reg_sel=1) with rs_data=0x200 -> pc=0x200; rs_data=0x202 -> addr_err=1, HALT, no further imem_req. R-type ADD with jump_reg_sel=1 -> pc+4.
- No ack for ACK_TIMEOUT=16 cycles -> fetch_err=1 on the 16th; req stays high; later ack is accepted normally.
- rst_n=0 during FETCH with ack in the same cycle, and separately during EXEC with retire -> pc=RESET_PC, instr_valid=0, imem_req=0 next cycle.
